// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry type codes for the reorder buffer and its neighbours.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 16;
    localparam int ROB_POS_WID = $clog2(ROB_SIZE);
    localparam int ROB_ID_WID  = ROB_POS_WID;
    localparam int REG_POS_WID = 5;
    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;
    localparam int CNT_WID     = 32;

    typedef enum logic [1:0] {
        ROB_TYPE_REG = 2'd0,
        ROB_TYPE_BR  = 2'd1,
        ROB_TYPE_ST  = 2'd2
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates rename positions, collects
// ALU/LSB results, retires one entry per cycle and raises rollback on a
// mispredicted branch.
// Optional build macro ROB_PERF_CNT_EN adds commit / mispredict counters.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   rollback,
    output logic                   rob_full,
    output logic [ROB_POS_WID-1:0] rob_next_pos,
    input  logic                   issue,
    input  logic [REG_POS_WID-1:0] issue_rd,
    input  logic [1:0]             issue_type,
    input  logic [ADDR_WID-1:0]    issue_pc,
    input  logic                   issue_pred_jump,
    input  logic                   alu_result,
    input  logic [ROB_POS_WID-1:0] alu_result_pos,
    input  logic [DATA_WID-1:0]    alu_result_val,
    input  logic                   alu_result_jump,
    input  logic [ADDR_WID-1:0]    alu_result_pc,
    input  logic                   lsb_result,
    input  logic [ROB_POS_WID-1:0] lsb_result_pos,
    input  logic [DATA_WID-1:0]    lsb_result_val,
    input  logic [ROB_POS_WID-1:0] query_rs1_pos,
    output logic                   query_rs1_ready,
    output logic [DATA_WID-1:0]    query_rs1_val,
    input  logic [ROB_POS_WID-1:0] query_rs2_pos,
    output logic                   query_rs2_ready,
    output logic [DATA_WID-1:0]    query_rs2_val,
    output logic                   rob_commit,
    output logic [REG_POS_WID-1:0] rob_commit_rd,
    output logic [DATA_WID-1:0]    rob_commit_val,
    output logic [ROB_POS_WID-1:0] rob_commit_rob_pos,
    output logic                   lsb_store_commit,
    output logic [ADDR_WID-1:0]    rollback_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [CNT_WID-1:0]     perf_commit_cnt,
    output logic [CNT_WID-1:0]     perf_mispredict_cnt
`endif
);

    localparam logic [ROB_POS_WID:0]   FULL_CNT = (ROB_POS_WID+1)'(ROB_SIZE);
    localparam logic [ROB_POS_WID-1:0] POS_ONE  = ROB_POS_WID'(1);

    logic [ROB_POS_WID-1:0] head;
    logic [ROB_POS_WID-1:0] tail;
    logic [ROB_POS_WID:0]   count;

    logic [ROB_SIZE-1:0]    busy;
    logic [ROB_SIZE-1:0]    ready;
    logic [ROB_SIZE-1:0]    ent_pred_jump;
    logic [ROB_SIZE-1:0]    ent_real_jump;
    rob_type_e              ent_type    [ROB_SIZE];
    logic [REG_POS_WID-1:0] ent_rd      [ROB_SIZE];
    logic [DATA_WID-1:0]    ent_val     [ROB_SIZE];
    logic [ADDR_WID-1:0]    ent_jump_pc [ROB_SIZE];

    logic issue_acc;
    logic alu_acc;
    logic lsb_acc;
    logic head_done;
    logic head_is_st;
    logic head_misp;

    // The redirect target is supplied by the ALU, so the issue PC is not kept.
    logic unused_issue_pc;
    assign unused_issue_pc = ^issue_pc;

    assign rob_full     = (count == FULL_CNT);
    assign rob_next_pos = tail;

    // Accept/commit qualifiers; nothing is accepted while stalled or flushing.
    always_comb begin
        issue_acc  = rdy && !rollback && issue && !rob_full;
        alu_acc    = rdy && !rollback && alu_result && busy[alu_result_pos];
        lsb_acc    = rdy && !rollback && lsb_result && busy[lsb_result_pos];
        head_done  = rdy && !rollback && busy[head] && ready[head];
        head_is_st = (ent_type[head] == ROB_TYPE_ST);
        head_misp  = (ent_type[head] == ROB_TYPE_BR) &&
                     (ent_real_jump[head] != ent_pred_jump[head]);
    end

    // Operand forwarding: a same-cycle writeback bypasses the stored entry.
    always_comb begin
        query_rs1_ready = ready[query_rs1_pos];
        query_rs1_val   = ent_val[query_rs1_pos];
        if (alu_result && alu_result_pos == query_rs1_pos) begin
            query_rs1_ready = 1'b1;
            query_rs1_val   = alu_result_val;
        end else if (lsb_result && lsb_result_pos == query_rs1_pos) begin
            query_rs1_ready = 1'b1;
            query_rs1_val   = lsb_result_val;
        end

        query_rs2_ready = ready[query_rs2_pos];
        query_rs2_val   = ent_val[query_rs2_pos];
        if (alu_result && alu_result_pos == query_rs2_pos) begin
            query_rs2_ready = 1'b1;
            query_rs2_val   = alu_result_val;
        end else if (lsb_result && lsb_result_pos == query_rs2_pos) begin
            query_rs2_ready = 1'b1;
            query_rs2_val   = lsb_result_val;
        end
    end

    // Pointers, occupancy, status bits and registered commit/rollback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            busy               <= '0;
            ready              <= '0;
            rollback           <= 1'b0;
            rollback_pc        <= '0;
            rob_commit         <= 1'b0;
            rob_commit_rd      <= '0;
            rob_commit_val     <= '0;
            rob_commit_rob_pos <= '0;
            lsb_store_commit   <= 1'b0;
        end else if (rdy) begin
            rob_commit       <= 1'b0;
            lsb_store_commit <= 1'b0;
            rollback         <= 1'b0;
            if (rollback) begin
                // Flush cycle: everything younger than the branch is dropped.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (alu_acc) begin
                    ready[alu_result_pos] <= 1'b1;
                end
                if (lsb_acc) begin
                    ready[lsb_result_pos] <= 1'b1;
                end
                if (head_done) begin
                    busy[head]         <= 1'b0;
                    ready[head]        <= 1'b0;
                    head               <= head + POS_ONE;
                    rob_commit_rob_pos <= head;
                    if (head_is_st) begin
                        lsb_store_commit <= 1'b1;
                    end else begin
                        rob_commit     <= 1'b1;
                        rob_commit_rd  <= ent_rd[head];
                        rob_commit_val <= ent_val[head];
                    end
                    if (head_misp) begin
                        rollback    <= 1'b1;
                        rollback_pc <= ent_jump_pc[head];
                    end
                end
                if (issue_acc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= (rob_type_e'(issue_type) == ROB_TYPE_ST);
                    tail        <= tail + POS_ONE;
                end
                count <= count + (ROB_POS_WID+1)'(issue_acc)
                               - (ROB_POS_WID+1)'(head_done);
            end
        end else begin
            rob_commit       <= 1'b0;
            lsb_store_commit <= 1'b0;
        end
    end

    // Entry payload; validity lives in busy/ready so no reset is needed here.
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            ent_type[tail]      <= rob_type_e'(issue_type);
            ent_rd[tail]        <= issue_rd;
            ent_val[tail]       <= '0;
            ent_pred_jump[tail] <= issue_pred_jump;
            ent_real_jump[tail] <= 1'b0;
            ent_jump_pc[tail]   <= '0;
        end
        if (alu_acc) begin
            ent_val[alu_result_pos]       <= alu_result_val;
            ent_real_jump[alu_result_pos] <= alu_result_jump;
            ent_jump_pc[alu_result_pos]   <= alu_result_pc;
        end
        if (lsb_acc && ent_type[lsb_result_pos] != ROB_TYPE_ST) begin
            ent_val[lsb_result_pos] <= lsb_result_val;
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Event counters survive rollback; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt     <= '0;
            perf_mispredict_cnt <= '0;
        end else begin
            if (head_done && !head_is_st) begin
                perf_commit_cnt <= perf_commit_cnt + CNT_WID'(1);
            end
            if (head_done && head_misp) begin
                perf_mispredict_cnt <= perf_mispredict_cnt + CNT_WID'(1);
            end
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard plus query vectors.
`timescale 1ns/1ps
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        rollback, rob_full;
    logic [3:0]  rob_next_pos;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_type;
    logic [31:0] issue_pc;
    logic        issue_pred_jump;
    logic        alu_result;
    logic [3:0]  alu_result_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;
    logic        lsb_result;
    logic [3:0]  lsb_result_pos;
    logic [31:0] lsb_result_val;
    logic [3:0]  query_rs1_pos, query_rs2_pos;
    logic        query_rs1_ready, query_rs2_ready;
    logic [31:0] query_rs1_val, query_rs2_val;
    logic        rob_commit;
    logic [4:0]  rob_commit_rd;
    logic [31:0] rob_commit_val;
    logic [3:0]  rob_commit_rob_pos;
    logic        lsb_store_commit;
    logic [31:0] rollback_pc;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt, perf_mispredict_cnt;
`endif

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rollback(rollback), .rob_full(rob_full), .rob_next_pos(rob_next_pos),
        .issue(issue), .issue_rd(issue_rd), .issue_type(issue_type),
        .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
        .alu_result(alu_result), .alu_result_pos(alu_result_pos),
        .alu_result_val(alu_result_val), .alu_result_jump(alu_result_jump),
        .alu_result_pc(alu_result_pc),
        .lsb_result(lsb_result), .lsb_result_pos(lsb_result_pos),
        .lsb_result_val(lsb_result_val),
        .query_rs1_pos(query_rs1_pos), .query_rs1_ready(query_rs1_ready),
        .query_rs1_val(query_rs1_val),
        .query_rs2_pos(query_rs2_pos), .query_rs2_ready(query_rs2_ready),
        .query_rs2_val(query_rs2_val),
        .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd),
        .rob_commit_val(rob_commit_val), .rob_commit_rob_pos(rob_commit_rob_pos),
        .lsb_store_commit(lsb_store_commit), .rollback_pc(rollback_pc)
`ifdef ROB_PERF_CNT_EN
        , .perf_commit_cnt(perf_commit_cnt), .perf_mispredict_cnt(perf_mispredict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pos;
        logic [4:0] rd;
        logic       st;
    } exp_t;

    typedef struct {
        logic [3:0]  q;
        logic        alu_v;
        logic [3:0]  alu_pos;
        logic [31:0] alu_val;
        logic        lsb_v;
        logic [3:0]  lsb_pos;
        logic [31:0] lsb_val;
        logic        exp_rdy;
        logic        chk_val;
        logic [31:0] exp_val;
    } qvec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_val [16];
    logic [3:0]  m_tail;
    qvec_t       qv [8];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue      = 1'b0;
        alu_result = 1'b0;
        lsb_result = 1'b0;
    endtask

    task automatic drv_issue(input logic [4:0] rd, input logic [1:0] typ,
                             input logic pj, input logic accept);
        issue           = 1'b1;
        issue_rd        = rd;
        issue_type      = typ;
        issue_pred_jump = pj;
        issue_pc        = {22'd0, rd, 5'd0};
        if (accept) begin
            exp_q.push_back('{pos: m_tail, rd: rd, st: (typ == 2'd2)});
            m_tail = m_tail + 4'd1;
        end
    endtask

    task automatic drv_alu(input logic [3:0] pos, input logic [31:0] val,
                           input logic jmp, input logic [31:0] pc);
        alu_result      = 1'b1;
        alu_result_pos  = pos;
        alu_result_val  = val;
        alu_result_jump = jmp;
        alu_result_pc   = pc;
        m_val[pos]      = val;
    endtask

    task automatic drv_lsb(input logic [3:0] pos, input logic [31:0] val, input logic is_st);
        lsb_result     = 1'b1;
        lsb_result_pos = pos;
        lsb_result_val = val;
        if (!is_st) m_val[pos] = val;
    endtask

    // Writing one position from both ports in the same cycle is illegal.
    always @(posedge clk) begin
        if (!rst)
            assert (!(alu_result && lsb_result && alu_result_pos == lsb_result_pos))
                else $error("ALU and LSB wrote position %0d together", alu_result_pos);
    end

    // Commit scoreboard: every retirement must match the oldest issued entry.
    always @(negedge clk) begin
        if (!rst && (rob_commit || lsb_store_commit)) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_commit: pos %0d retired, nothing outstanding",
                         rob_commit_rob_pos);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_pos", 32'(rob_commit_rob_pos), 32'(mon_e.pos));
                chk("commit_kind", {30'd0, rob_commit, lsb_store_commit},
                    mon_e.st ? 32'd1 : 32'd2);
                if (!mon_e.st) begin
                    chk("commit_rd", 32'(rob_commit_rd), 32'(mon_e.rd));
                    chk("commit_val", rob_commit_val, m_val[mon_e.pos]);
                end
            end
        end
    end

    initial begin
        logic [3:0] p;

        qv[0] = '{4'd3, 1'b1, 4'd3, 32'd7,     1'b0, 4'd0, 32'd0,     1'b1, 1'b1, 32'd7};
        qv[1] = '{4'd3, 1'b0, 4'd0, 32'd0,     1'b0, 4'd0, 32'd0,     1'b0, 1'b0, 32'd0};
        qv[2] = '{4'd2, 1'b0, 4'd0, 32'd0,     1'b0, 4'd0, 32'd0,     1'b1, 1'b1, 32'hAA};
        qv[3] = '{4'd0, 1'b0, 4'd0, 32'd0,     1'b1, 4'd0, 32'h55,    1'b1, 1'b1, 32'h55};
        qv[4] = '{4'd1, 1'b0, 4'd0, 32'd0,     1'b0, 4'd0, 32'd0,     1'b1, 1'b0, 32'd0};
        qv[5] = '{4'd0, 1'b1, 4'd3, 32'd9,     1'b0, 4'd0, 32'd0,     1'b0, 1'b0, 32'd0};
        qv[6] = '{4'd3, 1'b0, 4'd0, 32'd0,     1'b1, 4'd3, 32'h77,    1'b1, 1'b1, 32'h77};
        qv[7] = '{4'd2, 1'b1, 4'd2, 32'h1111,  1'b0, 4'd0, 32'd0,     1'b1, 1'b1, 32'h1111};

        for (int i = 0; i < 16; i++) m_val[i] = '0;
        m_tail = '0;
        rst = 1'b1; rdy = 1'b1;
        idle();
        issue_rd = '0; issue_type = '0; issue_pc = '0; issue_pred_jump = 1'b0;
        alu_result_pos = '0; alu_result_val = '0; alu_result_jump = 1'b0; alu_result_pc = '0;
        lsb_result_pos = '0; lsb_result_val = '0;
        query_rs1_pos = '0; query_rs2_pos = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_next_pos", 32'(rob_next_pos), 32'd0);
        chk("rst_commit", 32'(rob_commit), 32'd0);
        chk("rst_store_commit", 32'(lsb_store_commit), 32'd0);
        chk("rst_rollback", 32'(rollback), 32'd0);
        chk("rst_rollback_pc", rollback_pc, 32'd0);
        chk("rst_commit_val", rob_commit_val, 32'd0);

        // Single issue, writeback, commit the following cycle.
        drv_issue(5'd5, 2'd0, 1'b0, 1'b1);
        @(negedge clk); idle(); drv_alu(4'd0, 32'h1234, 1'b0, 32'd0);
        chk("t1_next_pos", 32'(rob_next_pos), 32'd1);
        chk("t1_no_early_commit", 32'(rob_commit), 32'd0);
        @(negedge clk); idle();
        chk("t1_wb_cycle", 32'(rob_commit), 32'd0);
        @(negedge clk);
        chk("t1_commit", 32'(rob_commit), 32'd1);
        @(negedge clk);
        chk("t1_strobe_once", 32'(rob_commit), 32'd0);
        chk("t1_not_full", 32'(rob_full), 32'd0);

        // Out-of-order writeback, in-order retirement (middle entry is a store).
        p = m_tail;
        drv_issue(5'd6, 2'd0, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd0, 2'd2, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd7, 2'd0, 1'b0, 1'b1);
        @(negedge clk); idle(); drv_alu(p + 4'd2, 32'hBEEF, 1'b0, 32'd0);
        @(negedge clk); idle(); drv_lsb(p + 4'd1, 32'hDEAD, 1'b1);
        chk("t2_hold_a", 32'(rob_commit | lsb_store_commit), 32'd0);
        @(negedge clk); idle(); drv_alu(p, 32'hCAFE, 1'b0, 32'd0);
        chk("t2_hold_b", 32'(rob_commit | lsb_store_commit), 32'd0);
        @(negedge clk); idle();
        chk("t2_hold_c", 32'(rob_commit | lsb_store_commit), 32'd0);
        @(negedge clk); chk("t2_commit0", 32'(rob_commit), 32'd1);
        @(negedge clk); chk("t2_commit1_store", 32'(lsb_store_commit), 32'd1);
        @(negedge clk); chk("t2_commit2", 32'(rob_commit), 32'd1);
        @(negedge clk); chk("t2_done", 32'(rob_commit | lsb_store_commit), 32'd0);

        // Fill to 16 from position 0, reject the 17th, free one and wrap.
        rst = 1'b1; idle();
        @(negedge clk); rst = 1'b0; exp_q.delete(); m_tail = '0;
        for (int i = 0; i < 16; i++) begin
            drv_issue(5'(i + 1), 2'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        chk("t3_full", 32'(rob_full), 32'd1);
        chk("t3_tail_wrapped", 32'(rob_next_pos), 32'd0);
        drv_issue(5'd31, 2'd0, 1'b0, 1'b0);
        @(negedge clk); idle();
        chk("t3_17th_ignored", 32'(rob_next_pos), 32'd0);
        chk("t3_still_full", 32'(rob_full), 32'd1);
        drv_alu(4'd0, 32'h5000, 1'b0, 32'd0);
        @(negedge clk); idle();
        @(negedge clk);
        chk("t3_commit_head", 32'(rob_commit), 32'd1);
        chk("t3_not_full_after_commit", 32'(rob_full), 32'd0);
        drv_issue(5'd20, 2'd0, 1'b0, 1'b1);
        @(negedge clk); idle();
        chk("t3_wrap_issue_pos", 32'(rob_next_pos), 32'd1);
        chk("t3_full_again", 32'(rob_full), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            drv_alu(4'(k % 16), 32'h6000 + 32'(k), 1'b0, 32'd0);
            @(negedge clk);
        end
        idle();
        repeat (20) @(negedge clk);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_empty", 32'(rob_full), 32'd0);

        // Mispredicted branch: rollback with its commit, flush next cycle.
        p = m_tail;
        drv_issue(5'd0, 2'd1, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd9, 2'd0, 1'b0, 1'b1);
        @(negedge clk); idle(); drv_alu(p, 32'd0, 1'b1, 32'h100);
        @(negedge clk); idle(); drv_alu(p + 4'd1, 32'h999, 1'b0, 32'd0);
        @(negedge clk); idle();
        chk("t4_rollback", 32'(rollback), 32'd1);
        chk("t4_rollback_pc", rollback_pc, 32'h100);
        chk("t4_branch_commit", 32'(rob_commit), 32'd1);
        drv_issue(5'd11, 2'd0, 1'b0, 1'b0);
        @(negedge clk); idle();
        exp_q.delete(); m_tail = '0;
        chk("t4_rollback_pulse", 32'(rollback), 32'd0);
        chk("t4_flush_tail", 32'(rob_next_pos), 32'd0);
        chk("t4_flush_commit", 32'(rob_commit), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_flush_empty", 32'(rob_full | rob_commit), 32'd0);

        // Operand query with same-cycle bypass (writebacks removed before the edge).
        drv_issue(5'd1, 2'd0, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd0, 2'd2, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd3, 2'd0, 1'b0, 1'b1);
        @(negedge clk); drv_issue(5'd4, 2'd0, 1'b0, 1'b1);
        @(negedge clk); idle(); drv_alu(4'd2, 32'hAA, 1'b0, 32'd0);
        @(negedge clk); idle();
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            query_rs1_pos  = qv[v].q;
            query_rs2_pos  = qv[v].q;
            alu_result     = qv[v].alu_v;
            alu_result_pos = qv[v].alu_pos;
            alu_result_val = qv[v].alu_val;
            lsb_result     = qv[v].lsb_v;
            lsb_result_pos = qv[v].lsb_pos;
            lsb_result_val = qv[v].lsb_val;
            #1;
            chk($sformatf("q%0d_rs1_ready", v), 32'(query_rs1_ready), 32'(qv[v].exp_rdy));
            chk($sformatf("q%0d_rs2_ready", v), 32'(query_rs2_ready), 32'(qv[v].exp_rdy));
            if (qv[v].chk_val) begin
                chk($sformatf("q%0d_rs1_val", v), query_rs1_val, qv[v].exp_val);
                chk($sformatf("q%0d_rs2_val", v), query_rs2_val, qv[v].exp_val);
            end
            idle();
        end

        // Reset with 10 entries busy and the head about to retire.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drv_issue(5'(10 + i), 2'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        idle(); drv_alu(4'd0, 32'h42, 1'b0, 32'd0);
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk);
        chk("t6_commit", 32'(rob_commit), 32'd0);
        chk("t6_store_commit", 32'(lsb_store_commit), 32'd0);
        chk("t6_next_pos", 32'(rob_next_pos), 32'd0);
        chk("t6_full", 32'(rob_full), 32'd0);
        chk("t6_rollback", 32'(rollback), 32'd0);
        chk("t6_commit_rd", 32'(rob_commit_rd), 32'd0);
        chk("t6_commit_val", rob_commit_val, 32'd0);
        rst = 1'b0; exp_q.delete(); m_tail = '0;
        repeat (3) @(negedge clk);
        chk("t6_no_stale_commit", 32'(rob_commit | lsb_store_commit), 32'd0);
        chk("t6_next_pos_hold", 32'(rob_next_pos), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
